// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - FP32 field layout, constants, NaN test and dot-accumulator FSM states
package fp32_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } dot_state_t;

    function automatic logic is_nan(input logic [31:0] x);
        return (&x[SIGN_BIT-1 -: EXP_W]) && (|x[MANT_W-1:0]);
    endfunction

endpackage

// File: rtl/fp32_add.sv
// rtl/fp32_add.sv - combinational FP32 adder, round-to-nearest-even, denormals flushed to zero
module fp32_add
    import fp32_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);

    logic [31:0]         w_x;
    logic [31:0]         w_y;
    logic [EXP_W-1:0]    w_ex;
    logic [EXP_W-1:0]    w_ey;
    logic [EXP_W-1:0]    w_d;
    logic [27:0]         w_mx;
    logic [27:0]         w_my;
    logic [27:0]         w_my_al;
    logic [27:0]         w_sum;
    logic                w_st;
    logic                w_found;
    logic [4:0]          w_sh;
    logic signed [9:0]   w_exp;
    logic [23:0]         w_mant;
    logic                w_g;
    logic                w_s;
    logic                w_up;
    logic [24:0]         w_rnd;

    // Order by magnitude, align with guard/round/sticky bits, add or subtract, normalise and round
    always_comb begin
        if (i_a[SIGN_BIT-1:0] >= i_b[SIGN_BIT-1:0]) begin
            w_x = i_a;
            w_y = i_b;
        end else begin
            w_x = i_b;
            w_y = i_a;
        end
        w_ex = w_x[SIGN_BIT-1 -: EXP_W];
        w_ey = w_y[SIGN_BIT-1 -: EXP_W];
        w_d  = w_ex - w_ey;
        w_mx = {2'b01, w_x[MANT_W-1:0], 3'b000};
        w_my = {2'b01, w_y[MANT_W-1:0], 3'b000};
        if (w_d >= 8'd27) begin
            w_my_al = '0;
            w_st    = 1'b1;
        end else begin
            w_my_al = w_my >> w_d;
            w_st    = |(w_my & ((28'd1 << w_d) - 28'd1));
        end
        w_my_al[0] = w_my_al[0] | w_st;

        w_exp   = $signed({2'b00, w_ex});
        w_sh    = '0;
        w_found = 1'b0;
        if (w_x[SIGN_BIT] == w_y[SIGN_BIT]) begin
            w_sum = w_mx + w_my_al;
            if (w_sum[27]) begin
                w_sum = {1'b0, w_sum[27:2], w_sum[1] | w_sum[0]};
                w_exp = w_exp + 10'sd1;
            end
        end else begin
            w_sum = w_mx - w_my_al;
            for (int i = 26; i >= 0; i--) begin
                if (!w_found) begin
                    if (w_sum[i]) w_found = 1'b1;
                    else          w_sh    = w_sh + 5'd1;
                end
            end
            w_sum = w_sum << w_sh;
            w_exp = w_exp - $signed({5'b00000, w_sh});
        end

        w_mant = w_sum[26:3];
        w_g    = w_sum[2];
        w_s    = |w_sum[1:0];
        w_up   = w_g & (w_s | w_mant[0]);
        w_rnd  = {1'b0, w_mant} + {24'b0, w_up};
        if (w_rnd[24]) begin
            w_mant = w_rnd[24:1];
            w_exp  = w_exp + 10'sd1;
        end else begin
            w_mant = w_rnd[23:0];
        end

        if (is_nan(i_a) || is_nan(i_b)) begin
            o_sum = FP32_QNAN;
        end else if (&w_ex) begin
            o_sum = ((&w_ey) && (w_x[SIGN_BIT] != w_y[SIGN_BIT])) ? FP32_QNAN : w_x;
        end else if (w_ey == '0) begin
            o_sum = (w_ex == '0) ? {w_x[SIGN_BIT] & w_y[SIGN_BIT], 31'b0} : w_x;
        end else if (w_sum == '0) begin
            o_sum = FP32_ZERO;
        end else if (w_exp >= 10'sd255) begin
            o_sum = {w_x[SIGN_BIT], 8'hFF, 23'b0};
        end else if (w_exp <= 10'sd0) begin
            o_sum = {w_x[SIGN_BIT], 31'b0};
        end else begin
            o_sum = {w_x[SIGN_BIT], w_exp[7:0], w_mant[MANT_W-1:0]};
        end
    end

endmodule

// File: rtl/fp32_dot_ctrl.sv
// rtl/fp32_dot_ctrl.sv - vector FSM, element counter, handshakes and last/clr decisions
module fp32_dot_ctrl
    import fp32_pkg::*;
#(
    parameter int VEC_LEN = 4,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             i_in_valid,
    input  logic             i_in_last,
    input  logic             i_out_ready,
    input  logic             i_prod_v,
    input  logic             i_prod_last,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic             o_accept,
    output logic             o_elem_last,
    output logic             o_load,
    output logic             o_hs,
    output logic [CNT_W-1:0] o_cnt
);

    dot_state_t       r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_cnt;
    int               w_pending;

    // An element is last on in_last or when it would be the VEC_LEN-th of the vector,
    // counting the one already added, the one waiting in the product stage and itself
    always_comb begin
        w_pending   = int'(r_cnt) + (i_prod_v ? 1 : 0) + 1;
        o_accept    = i_in_valid && r_in_ready && !clr;
        o_elem_last = i_in_last || (w_pending >= VEC_LEN);
        o_load      = (r_state == DRAIN) && i_prod_last && !clr;
        o_hs        = (r_state == HOLD) && r_out_valid && i_out_ready && !clr;
    end

    // Vector FSM with registered in_ready/out_valid and the count of elements added
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state     <= ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (i_prod_v) r_cnt <= r_cnt + CNT_W'(1);
            case (r_state)
                ACCUM: begin
                    if (o_accept && o_elem_last) begin
                        r_state    <= DRAIN;
                        r_in_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    r_state     <= HOLD;
                    r_out_valid <= 1'b1;
                end
                HOLD: begin
                    if (o_hs) begin
                        r_state     <= ACCUM;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                default: begin
                    r_state     <= ACCUM;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_cnt       = r_cnt;

endmodule

// File: rtl/fp32_mul.sv
// rtl/fp32_mul.sv - combinational FP32 multiplier, round-to-nearest-even, denormals flushed to zero
module fp32_mul
    import fp32_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_p
);

    logic                w_sign;
    logic [EXP_W-1:0]    w_ea;
    logic [EXP_W-1:0]    w_eb;
    logic [47:0]         w_prod;
    logic signed [9:0]   w_exp;
    logic [23:0]         w_mant;
    logic                w_g;
    logic                w_s;
    logic                w_up;
    logic [24:0]         w_rnd;

    // Multiply significands, normalise the 48-bit product, round and resolve special operands
    always_comb begin
        w_sign = i_a[SIGN_BIT] ^ i_b[SIGN_BIT];
        w_ea   = i_a[SIGN_BIT-1 -: EXP_W];
        w_eb   = i_b[SIGN_BIT-1 -: EXP_W];
        w_prod = {24'b0, 1'b1, i_a[MANT_W-1:0]} * {24'b0, 1'b1, i_b[MANT_W-1:0]};
        w_exp  = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;
        if (w_prod[47]) begin
            w_mant = w_prod[47:24];
            w_g    = w_prod[23];
            w_s    = |w_prod[22:0];
            w_exp  = w_exp + 10'sd1;
        end else begin
            w_mant = w_prod[46:23];
            w_g    = w_prod[22];
            w_s    = |w_prod[21:0];
        end
        w_up  = w_g & (w_s | w_mant[0]);
        w_rnd = {1'b0, w_mant} + {24'b0, w_up};
        if (w_rnd[24]) begin
            w_mant = w_rnd[24:1];
            w_exp  = w_exp + 10'sd1;
        end else begin
            w_mant = w_rnd[23:0];
        end

        if (is_nan(i_a) || is_nan(i_b)) begin
            o_p = FP32_QNAN;
        end else if (&w_ea) begin
            o_p = (w_eb == '0) ? FP32_QNAN : {w_sign, 8'hFF, 23'b0};
        end else if (&w_eb) begin
            o_p = (w_ea == '0) ? FP32_QNAN : {w_sign, 8'hFF, 23'b0};
        end else if ((w_ea == '0) || (w_eb == '0)) begin
            o_p = {w_sign, 31'b0};
        end else if (w_exp >= 10'sd255) begin
            o_p = {w_sign, 8'hFF, 23'b0};
        end else if (w_exp <= 10'sd0) begin
            o_p = {w_sign, 31'b0};
        end else begin
            o_p = {w_sign, w_exp[7:0], w_mant[MANT_W-1:0]};
        end
    end

endmodule

// File: rtl/fp32_dot_accumulator.sv
// rtl/fp32_dot_accumulator.sv - pipelined FP32 multiply-accumulate over framed vectors
module fp32_dot_accumulator
    import fp32_pkg::*;
#(
    parameter int          VEC_LEN  = 4,
    parameter logic [31:0] ACC_INIT = 32'h0000_0000,
    parameter int          CNT_W    = $clog2(VEC_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_nan
);

    logic [31:0]      r_prod_q;
    logic             r_prod_v;
    logic             r_prod_last;
    logic             r_prod_nan;
    logic [31:0]      r_acc;
    logic             r_nan;
    logic [31:0]      r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_nan;

    logic [31:0]      w_mul;
    logic [31:0]      w_sum;
    logic             w_accept;
    logic             w_elem_last;
    logic             w_load;
    logic             w_hs;
    logic [CNT_W-1:0] w_cnt;

    fp32_mul u_mul (
        .i_a (in_a),
        .i_b (in_b),
        .o_p (w_mul)
    );

    fp32_add u_add (
        .i_a   (r_acc),
        .i_b   (r_prod_q),
        .o_sum (w_sum)
    );

    fp32_dot_ctrl #(
        .VEC_LEN (VEC_LEN),
        .CNT_W   (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .i_in_valid  (in_valid),
        .i_in_last   (in_last),
        .i_out_ready (out_ready),
        .i_prod_v    (r_prod_v),
        .i_prod_last (r_prod_last),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_accept    (w_accept),
        .o_elem_last (w_elem_last),
        .o_load      (w_load),
        .o_hs        (w_hs),
        .o_cnt       (w_cnt)
    );

    // Product stage, accumulator, NaN sticky and the registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod_q    <= FP32_ZERO;
            r_prod_v    <= 1'b0;
            r_prod_last <= 1'b0;
            r_prod_nan  <= 1'b0;
            r_acc       <= ACC_INIT;
            r_nan       <= 1'b0;
            r_out_data  <= FP32_ZERO;
            r_out_count <= '0;
            r_out_nan   <= 1'b0;
        end else if (clr) begin
            r_prod_v    <= 1'b0;
            r_prod_last <= 1'b0;
            r_prod_nan  <= 1'b0;
            r_acc       <= ACC_INIT;
            r_nan       <= 1'b0;
        end else begin
            r_prod_v <= w_accept;
            if (w_accept) begin
                r_prod_q    <= w_mul;
                r_prod_last <= w_elem_last;
                r_prod_nan  <= is_nan(in_a) || is_nan(in_b);
            end
            if (w_hs) begin
                r_acc <= ACC_INIT;
                r_nan <= 1'b0;
            end else if (r_prod_v) begin
                r_acc <= w_sum;
                r_nan <= r_nan | r_prod_nan;
            end
            if (w_load) begin
                r_out_data  <= w_sum;
                r_out_count <= w_cnt + CNT_W'(1);
                r_out_nan   <= r_nan | r_prod_nan;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_nan   = r_out_nan;

endmodule

// File: tb/tb_fp32_dot_accumulator.sv
// tb/tb_fp32_dot_accumulator.sv - self-checking bench for fp32_dot_accumulator
module tb_fp32_dot_accumulator;
    import fp32_pkg::*;

    localparam int VEC_LEN = 4;
    localparam int CNT_W   = $clog2(VEC_LEN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_nan;

    int checks = 0;
    int errors = 0;

    fp32_dot_accumulator #(
        .VEC_LEN  (VEC_LEN),
        .ACC_INIT (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_nan   (out_nan)
    );

    always #5 clk = ~clk;

    // exact FP32 encoding of n / 2**fbits (valid while |n| < 2**24)
    function automatic logic [31:0] to_fp32(input longint n, input int fbits);
        longint m;
        int     p;
        logic   s;
        if (n == 0) return 32'h0000_0000;
        s = (n < 0);
        m = s ? -n : n;
        p = 0;
        for (int i = 0; i < 40; i++) if (m[i]) p = i;
        return {s, 8'(p - fbits + 127), 23'(m << (23 - p))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic last, output logic taken);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        taken    = in_ready;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else           tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, out_data, out_count, out_nan} !== {1'b1, 1'b0, 32'h0, CNT_W'(0), 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b data=%h count=%0d nan=%b, expected 1 0 00000000 0 0",
                     in_ready, out_valid, out_data, out_count, out_nan);
        end
    endtask

    task automatic test_full_vector();
        logic [31:0] av [4];
        logic        tk;
        logic        all_tk;
        av[0] = FP32_ONE; av[1] = 32'h4000_0000; av[2] = 32'h4040_0000; av[3] = 32'h4080_0000;
        out_ready = 1'b1;
        all_tk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(av[i], 32'h4000_0000, 1'b0, tk);
            all_tk &= tk;
        end
        checks++;
        if (all_tk !== 1'b1) begin
            errors++; $display("FAIL full_accept: got all_taken=%b expected 1", all_tk);
        end
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            errors++; $display("FAIL full_after_last: got out_valid=%b in_ready=%b expected 0 0", out_valid, in_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_data, out_count, out_nan} !== {1'b1, 32'h41A0_0000, CNT_W'(4), 1'b0}) begin
            errors++;
            $display("FAIL full_result: got valid=%b data=%h count=%0d nan=%b expected 1 41a00000 4 0",
                     out_valid, out_data, out_count, out_nan);
        end
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL full_handshake: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_early_term();
        logic tk;
        logic seen;
        out_ready = 1'b0;
        drive(FP32_ONE, 32'h4000_0000, 1'b0, tk);
        drive(32'h4040_0000, 32'h4000_0000, 1'b1, tk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL early_in_ready: got %b expected 0", in_ready);
        end
        wait_valid(seen);
        tick(); tick();
        checks++;
        if ({seen, in_ready, out_data, out_count} !== {1'b1, 1'b0, 32'h4100_0000, CNT_W'(2)}) begin
            errors++;
            $display("FAIL early_result: got seen=%b in_ready=%b data=%h count=%0d expected 1 0 41000000 2",
                     seen, in_ready, out_data, out_count);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL early_handshake: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_pressure();
        logic        tk;
        logic        seen;
        logic        stable;
        logic [31:0] held;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) drive(to_fp32(i, 0), 32'h4000_0000, 1'b0, tk);
        wait_valid(seen);
        held   = out_data;
        stable = seen;
        for (int i = 0; i < 5; i++) begin
            drive(32'h4000_0000, 32'h4000_0000, 1'b0, tk);
            if (tk || !out_valid || in_ready || out_data !== held) stable = 1'b0;
        end
        checks++;
        if ({stable, held} !== {1'b1, 32'h41A0_0000}) begin
            errors++; $display("FAIL bp_hold: got stable=%b data=%h expected 1 41a00000", stable, held);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_handshake: got out_valid=%b expected 0", out_valid);
        end
        for (int i = 1; i <= 4; i++) drive(to_fp32(i, 0), 32'h4000_0000, 1'b0, tk);
        wait_valid(seen);
        checks++;
        if ({seen, out_data, out_count} !== {1'b1, 32'h41A0_0000, CNT_W'(4)}) begin
            errors++; $display("FAIL bp_repeat: got seen=%b data=%h count=%0d expected 1 41a00000 4", seen, out_data, out_count);
        end
        tick();
    endtask

    task automatic test_nan();
        logic tk;
        logic seen;
        out_ready = 1'b1;
        drive(FP32_ONE, 32'h4000_0000, 1'b0, tk);
        drive(FP32_QNAN, 32'h4000_0000, 1'b0, tk);
        drive(32'h4040_0000, 32'h4000_0000, 1'b0, tk);
        drive(32'h4080_0000, 32'h4000_0000, 1'b0, tk);
        wait_valid(seen);
        checks++;
        if ({seen, out_nan, out_count} !== {1'b1, 1'b1, CNT_W'(4)}) begin
            errors++; $display("FAIL nan_flag: got seen=%b nan=%b count=%0d expected 1 1 4", seen, out_nan, out_count);
        end
        tick();
        drive(32'h4000_0000, 32'h4040_0000, 1'b1, tk);
        wait_valid(seen);
        checks++;
        if ({seen, out_nan, out_data} !== {1'b1, 1'b0, 32'h40C0_0000}) begin
            errors++; $display("FAIL nan_cleared: got seen=%b nan=%b data=%h expected 1 0 40c00000", seen, out_nan, out_data);
        end
        tick();
    endtask

    task automatic test_clr();
        logic tk;
        logic seen;
        out_ready = 1'b1;
        drive(32'h4080_0000, 32'h4080_0000, 1'b0, tk);
        drive(32'h4080_0000, 32'h4080_0000, 1'b0, tk);
        clr = 1'b1;
        drive(32'h4080_0000, 32'h4080_0000, 1'b0, tk);
        clr = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL clr_state: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        drive(32'h4000_0000, 32'h4040_0000, 1'b1, tk);
        wait_valid(seen);
        checks++;
        if ({seen, out_data, out_count, out_nan} !== {1'b1, 32'h40C0_0000, CNT_W'(1), 1'b0}) begin
            errors++;
            $display("FAIL clr_next_vector: got seen=%b data=%h count=%0d nan=%b expected 1 40c00000 1 0",
                     seen, out_data, out_count, out_nan);
        end
        tick();
        out_ready = 1'b0;
        drive(FP32_ONE, FP32_ONE, 1'b1, tk);
        wait_valid(seen);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({seen, out_valid, in_ready} !== 3'b101) begin
            errors++; $display("FAIL clr_hold_drop: got seen=%b out_valid=%b in_ready=%b expected 1 0 1", seen, out_valid, in_ready);
        end
    endtask

    task automatic test_rst_hold();
        logic tk;
        logic seen;
        logic spurious;
        out_ready = 1'b0;
        drive(32'h4040_0000, 32'h4040_0000, 1'b0, tk);
        drive(FP32_ONE, FP32_ONE, 1'b1, tk);
        wait_valid(seen);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({seen, out_valid, in_ready, out_data, out_count, out_nan} !== {1'b1, 1'b0, 1'b1, 32'h0, CNT_W'(0), 1'b0}) begin
            errors++;
            $display("FAIL rst_hold: got seen=%b valid=%b in_ready=%b data=%h count=%0d nan=%b expected 1 0 1 00000000 0 0",
                     seen, out_valid, in_ready, out_data, out_count, out_nan);
        end
        out_ready = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid) spurious = 1'b1;
        end
        checks++;
        if (spurious !== 1'b0) begin
            errors++; $display("FAIL rst_no_spurious: got out_valid pulse=%b expected 0", spurious);
        end
    endtask

    task automatic test_random();
        int          len;
        int          ka;
        int          kb;
        longint      acc;
        logic        tk;
        logic        last;
        logic        got;
        int          lost;
        logic [31:0] g_data;
        logic [CNT_W-1:0] g_cnt;
        logic        g_nan;
        logic [31:0] exp_data;
        lost = 0;
        for (int v = 0; v < 25; v++) begin
            len = int'($urandom_range(1, VEC_LEN));
            acc = 0;
            for (int e = 0; e < len; e++) begin
                ka = int'($urandom_range(0, 510)) - 255;
                kb = int'($urandom_range(0, 510)) - 255;
                acc += longint'(ka * kb);
                if (e != len - 1)        last = 1'b0;
                else if (len == VEC_LEN) last = 1'($urandom_range(0, 1));
                else                     last = 1'b1;
                drive(to_fp32(ka, 2), to_fp32(kb, 2), last, tk);
                if (!tk) lost++;
                if ($urandom_range(0, 3) == 0) tick();
            end
            exp_data  = to_fp32(acc, 4);
            got       = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            for (int i = 0; i < 40 && !got; i++) begin
                if (out_valid && out_ready) begin
                    got = 1'b1; g_data = out_data; g_cnt = out_count; g_nan = out_nan;
                end
                tick();
                out_ready = 1'($urandom_range(0, 1));
            end
            checks++;
            if (!got) begin
                errors++; $display("FAIL rand_timeout: vector %0d got no result, expected one", v);
            end else if ({g_data, g_cnt, g_nan} !== {exp_data, CNT_W'(len), 1'b0}) begin
                errors++;
                $display("FAIL rand_result: vector %0d got data=%h count=%0d nan=%b expected %h %0d 0",
                         v, g_data, g_cnt, g_nan, exp_data, len);
            end
        end
        checks++;
        if (lost !== 0) begin
            errors++; $display("FAIL rand_accept: got %0d refused elements expected 0", lost);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_vector();
        test_early_term();
        test_back_pressure();
        test_nan();
        test_clr();
        test_rst_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
